// File: rtl/adder_share_ctrl_if.sv
// adder_share_ctrl_if: requester and shared-adder signals of the adder sharing controller.
interface adder_share_ctrl_if #(parameter int WIDTH = 16);
    logic [2:0]         req;
    logic [2:0]         sub;
    logic [2:0]         done;
    logic [3*WIDTH-1:0] a_in;
    logic [3*WIDTH-1:0] b_in;
    logic [WIDTH-1:0]   result;
    logic               carry;
    logic               zero;
    logic               busy;
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH-1:0]   add_s;
    logic               add_c;
    modport master (
        output req, sub, a_in, b_in, add_s, add_c,
        input  done, result, carry, zero, busy, add_a, add_b, add_cin
    );
    modport slave (
        input  req, sub, a_in, b_in, add_s, add_c,
        output done, result, carry, zero, busy, add_a, add_b, add_cin
    );
endinterface

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: round-robin sequencer sharing one clocked ripple adder among three requesters.
module adder_share_ctrl #(
    parameter int WIDTH   = 16,
    parameter int ADD_LAT = 16
) (
    input logic clk,
    input logic rst,
    adder_share_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    state_t           state_q, state_d;
    logic [1:0]       rr_q, rr_d, gnt_q, gnt_d, c1, c2, sel;
    logic [4:0]       cnt_q, cnt_d;
    logic [2:0]       done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d, add_a_q, add_a_d, add_b_q, add_b_d;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic             carry_q, carry_d, zero_q, zero_d, cin_q, cin_d;
    function automatic logic [1:0] inc3(input logic [1:0] x);
        return x == 2'd2 ? 2'd0 : x + 2'd1;
    endfunction
    // first requester found scanning rr_q, rr_q+1, rr_q+2 (mod 3)
    assign c1    = inc3(rr_q);
    assign c2    = inc3(c1);
    assign sel   = bus.req[rr_q] ? rr_q : bus.req[c1] ? c1 : c2;
    assign a_sel = bus.a_in[sel*WIDTH +: WIDTH];
    assign b_sel = bus.b_in[sel*WIDTH +: WIDTH];
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        done_d   = '0;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        add_a_d  = add_a_q;
        add_b_d  = add_b_q;
        cin_d    = cin_q;
        if (state_q == S_IDLE && bus.req != 3'b000) begin
            gnt_d   = sel;
            add_a_d = a_sel;
            add_b_d = bus.sub[sel] ? ~b_sel : b_sel;
            cin_d   = bus.sub[sel];
            cnt_d   = 5'(ADD_LAT - 1);
            state_d = S_WAIT;
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q != 5'd0 ? cnt_q - 5'd1 : cnt_q;
            if (cnt_q == 5'd0) begin
                result_d = bus.add_s;
                carry_d  = bus.add_c;
                zero_d   = bus.add_s == '0;
                done_d   = 3'b001 << gnt_q;
                rr_d     = inc3(gnt_q);
                state_d  = S_DONE;
            end
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_q     <= 2'd0;
            gnt_q    <= 2'd0;
            cnt_q    <= 5'd0;
            done_q   <= 3'b000;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            add_a_q  <= '0;
            add_b_q  <= '0;
            cin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            add_a_q  <= add_a_d;
            add_b_q  <= add_b_d;
            cin_q    <= cin_d;
        end
    end
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.carry   = carry_q;
    assign bus.zero    = zero_q;
    assign bus.busy    = state_q != S_IDLE;
    assign bus.add_a   = add_a_q;
    assign bus.add_b   = add_b_q;
    assign bus.add_cin = cin_q;
endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb_adder_share_ctrl: scoreboard bench with a latency-aware adder model and a cycle-level reference model.
module tb_adder_share_ctrl;
    localparam int W = 16;
    localparam int L = 16;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    adder_share_ctrl_if #(.WIDTH(W)) bus ();
    adder_share_ctrl_if #(.WIDTH(W)) bus1 ();
    adder_share_ctrl #(.WIDTH(W), .ADD_LAT(L)) dut  (.clk(clk), .rst(rst), .bus(bus));
    adder_share_ctrl #(.WIDTH(W), .ADD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    int errors = 0;
    int checks = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask
    // Adder model: sum is only trustworthy once inputs have been stable for the adder latency.
    function automatic logic [W:0] adder(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic ok);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        return ok ? s : ~s;
    endfunction
    logic [2*W:0] last0, last1;
    int held0 = 0;
    int held1 = 0;
    always @(negedge clk) begin
        held0 = ({bus.add_a, bus.add_b, bus.add_cin} !== last0) ? 1 : held0 + 1;
        last0 = {bus.add_a, bus.add_b, bus.add_cin};
        held1 = ({bus1.add_a, bus1.add_b, bus1.add_cin} !== last1) ? 1 : held1 + 1;
        last1 = {bus1.add_a, bus1.add_b, bus1.add_cin};
    end
    assign {bus.add_c, bus.add_s} = adder(bus.add_a, bus.add_b, bus.add_cin,
        {bus.add_a, bus.add_b, bus.add_cin} === last0 && held0 >= L);
    assign {bus1.add_c, bus1.add_s} = adder(bus1.add_a, bus1.add_b, bus1.add_cin,
        {bus1.add_a, bus1.add_b, bus1.add_cin} === last1 && held1 >= 1);
    // Reference model: schedule of grants and the arithmetic outcome of each op.
    typedef struct {int port; logic [W-1:0] r; logic c; logic z; int cyc;} exp_t;
    exp_t q[$];
    int cyc = 0;
    int rr = 0;
    int next_free = 0;
    int busy_end = 0;
    int g = -1000;
    logic [W-1:0] ea, eb;
    logic ecin;
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            rr = 0;
            next_free = cyc + 1;
            busy_end = 0;
            g = -1000;
        end else if (cyc >= next_free && bus.req != 3'b000) begin
            exp_t e;
            int p;
            logic [W-1:0] a, b;
            logic s;
            p = rr;
            for (int k = 0; k < 3; k++) begin
                p = (rr + k) % 3;
                if (bus.req[p]) break;
            end
            a = bus.a_in[p*W +: W];
            b = bus.b_in[p*W +: W];
            s = bus.sub[p];
            e.port = p;
            e.r = s ? a - b : a + b;
            e.c = s ? (a >= b) : (32'(a) + 32'(b) > 32'hFFFF);
            e.z = (e.r == 0);
            e.cyc = cyc + L;
            q.push_back(e);
            ea = a;
            eb = s ? ~b : b;
            ecin = s;
            g = cyc;
            busy_end = cyc + L + 1;
            next_free = cyc + L + 2;
            rr = (p + 1) % 3;
        end
    end
    always @(negedge clk) begin
        chk("busy", 32'(bus.busy), 32'(cyc < busy_end));
        if (cyc >= g && cyc < g + L) begin
            chk("hold_add_a", 32'(bus.add_a), 32'(ea));
            chk("hold_add_b", 32'(bus.add_b), 32'(eb));
            chk("hold_add_cin", 32'(bus.add_cin), 32'(ecin));
        end
        if (bus.done != 3'b000) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected act=%b exp=000", bus.done);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_port", 32'(bus.done), 32'(1 << e.port));
                chk("result", 32'(bus.result), 32'(e.r));
                chk("carry", 32'(bus.carry), 32'(e.c));
                chk("zero", 32'(bus.zero), 32'(e.z));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL done_missing act=000 exp_port=%0d", q[0].port);
            void'(q.pop_front());
        end
    end
    function automatic logic [W-1:0] rnd();
        case ($urandom_range(0, 3))
            0: return 16'h0000;
            1: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction
    task automatic do_op(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] exb, input logic [W-1:0] er, input logic ec, input logic ez,
                         input string nm);
        int n;
        @(negedge clk);
        bus.a_in[p*W +: W] = a;
        bus.b_in[p*W +: W] = b;
        bus.sub[p] = s;
        bus.req[p] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({nm, "_add_a"}, 32'(bus.add_a), 32'(a));
                chk({nm, "_add_b"}, 32'(bus.add_b), 32'(exb));
                chk({nm, "_add_cin"}, 32'(bus.add_cin), 32'(s));
            end
        end while (!bus.done[p] && n < 60);
        chk({nm, "_latency"}, 32'(n), 32'(L + 1));
        chk({nm, "_result"}, 32'(bus.result), 32'(er));
        chk({nm, "_carry"}, 32'(bus.carry), 32'(ec));
        chk({nm, "_zero"}, 32'(bus.zero), 32'(ez));
        bus.req[p] = 1'b0;
    endtask
    initial begin
        int n, k, prev, pulses;
        int gap[3];
        logic [2:0] order[4];
        rst = 1'b1;
        bus.req = '0; bus.sub = '0; bus.a_in = '0; bus.b_in = '0;
        bus1.req = '0; bus1.sub = '0; bus1.a_in = '0; bus1.b_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_result", 32'(bus.result), 32'(0));
        chk("rst_zero", 32'(bus.zero), 32'(1));
        chk("rst_carry", 32'(bus.carry), 32'(0));
        chk("rst_add_a", 32'(bus.add_a), 32'(0));
        chk("rst_add_b", 32'(bus.add_b), 32'(0));
        chk("rst_add_cin", 32'(bus.add_cin), 32'(0));
        rst = 1'b0;
        do_op(2, 16'h1234, 16'h0FF0, 1'b0, 16'h0FF0, 16'h2224, 1'b0, 1'b0, "add_p2");
        do_op(1, 16'h0003, 16'h0005, 1'b1, 16'hFFFA, 16'hFFFE, 1'b0, 1'b0, "sub_p1");
        do_op(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b1, "wrap_p0");
        // abort an op mid-WAIT, then serve the same request again
        @(negedge clk);
        bus.a_in[1*W +: W] = 16'h00FF; bus.b_in[1*W +: W] = 16'h0001; bus.sub[1] = 1'b0;
        bus.req[1] = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_done", 32'(bus.done), 32'(0));
        chk("abort_busy", 32'(bus.busy), 32'(0));
        chk("abort_add_a", 32'(bus.add_a), 32'(0));
        chk("abort_add_b", 32'(bus.add_b), 32'(0));
        rst = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.done[1] && n < 60);
        chk("abort_reserve_latency", 32'(n), 32'(L + 1));
        chk("abort_reserve_result", 32'(bus.result), 32'h0100);
        bus.req[1] = 1'b0;
        // round robin from reset with all ports requesting and operands churning
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.a_in = {16'h3000, 16'h2000, 16'h1000};
        bus.b_in = {16'h0003, 16'h0002, 16'h0001};
        bus.sub = '0;
        bus.req = 3'b111;
        k = 0; n = 0;
        while (k < 4 && n < 4 * (L + 2) + 20) begin
            @(negedge clk);
            n++;
            if (bus.done != 3'b000) begin
                order[k] = bus.done;
                k++;
                if (k == 4) bus.req = '0;
            end
            bus.a_in = {rnd(), rnd(), rnd()};
            bus.b_in = {rnd(), rnd(), rnd()};
        end
        chk("rr_count", 32'(k), 32'(4));
        chk("rr_order0", 32'(order[0]), 32'(3'b001));
        chk("rr_order1", 32'(order[1]), 32'(3'b010));
        chk("rr_order2", 32'(order[2]), 32'(3'b100));
        chk("rr_order3", 32'(order[3]), 32'(3'b001));
        bus.req = '0;
        repeat (L + 4) @(negedge clk);
        // random traffic; each port drops req in its done cycle
        gap = '{0, 0, 0};
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                if (bus.req[p]) begin
                    if (bus.done[p]) begin
                        bus.req[p] = 1'b0;
                        gap[p] = $urandom_range(0, 20);
                    end else if ($urandom_range(0, 3) == 0) begin
                        bus.a_in[p*W +: W] = rnd();
                        bus.b_in[p*W +: W] = rnd();
                        bus.sub[p] = 1'($urandom_range(0, 1));
                    end
                end else if (gap[p] > 0) begin
                    gap[p]--;
                end else if ($urandom_range(0, 2) == 0) begin
                    bus.a_in[p*W +: W] = rnd();
                    bus.b_in[p*W +: W] = rnd();
                    bus.sub[p] = 1'($urandom_range(0, 1));
                    bus.req[p] = 1'b1;
                end
            end
        end
        bus.req = '0;
        repeat (2 * L + 6) @(negedge clk);
        chk("drain_queue_empty", 32'(q.size()), 32'(0));
        // ADD_LAT=1 instance: continuous request on port 0
        bus1.a_in[0 +: W] = 16'h0101;
        bus1.b_in[0 +: W] = 16'h0202;
        bus1.req[0] = 1'b1;
        prev = -1;
        pulses = 0;
        for (int t = 0; t < 36; t++) begin
            @(negedge clk);
            if (bus1.done != 3'b000) begin
                chk("lat1_done", 32'(bus1.done), 32'(3'b001));
                chk("lat1_result", 32'(bus1.result), 32'h0303);
                if (prev < 0) chk("lat1_first", 32'(t), 32'(1));
                else chk("lat1_period", 32'(t - prev), 32'(3));
                prev = t;
                pulses++;
            end
        end
        chk("lat1_pulses", 32'(pulses), 32'(12));
        bus1.req = '0;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
